mp_hca_add_seq: RTL and testbench

//  Multi-precision add sequencer. Streams one W-bit operand pair through a single

---
 rtl/mp_hca_add_seq_pkg.sv | 8 +
 rtl/mp_hca_add_seq_if.sv | 22 ++
 rtl/mp_hca_add_seq_hca16_cin.sv | 28 ++
 rtl/mp_hca_add_seq.sv | 79 +++++++
 tb/tb_mp_hca_add_seq.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mp_hca_add_seq_pkg.sv
// mp_add_pkg: shared chunk width, sequencer state type and width legality helper
package mp_add_pkg;
  localparam int CHUNK = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic bit w_ok(int w);
    return w > 0 && w % CHUNK == 0;
  endfunction
endpackage

// File: rtl/mp_hca_add_seq_if.sv
// mp_hca_add_seq_if: operand (valid/ready) and result (valid/ready) channels of the sequencer
interface mp_hca_add_seq_if #(parameter int W = 64);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic in_cin;
  logic in_sub;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_sum;
  logic out_cout;
  logic out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/mp_hca_add_seq_hca16_cin.sv
// hca16_cin: combinational 16-bit Han-Carlson prefix adder with carry-in, s[16] is carry-out
module hca16_cin (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [16:0] s
);
  logic [15:0] p, gg, pp;
  always_comb begin
    p = x ^ y;
    gg = x & y;
    gg[0] = gg[0] | (p[0] & cin);
    pp = p;
    for (int i = 1; i < 16; i += 2) begin
      gg[i] = gg[i] | (pp[i] & gg[i-1]);
      pp[i] = pp[i] & pp[i-1];
    end
    // odd-only Kogge-Stone; descending order keeps each level reading its inputs unmodified
    for (int d = 2; d < 16; d *= 2)
      for (int i = 15; i > d; i -= 2) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    for (int i = 2; i < 16; i += 2)
      gg[i] = gg[i] | (pp[i] & gg[i-1]);
    s = {gg[15], p ^ {gg[14:0], cin}};
  end
endmodule

// File: rtl/mp_hca_add_seq.sv
// mp_hca_add_seq: W-bit add through one shared 16-bit Han-Carlson adder, LSB chunk first.
// Define MPADD_SUB_EN to enable A-B via in_sub.
module mp_hca_add_seq
  import mp_add_pkg::*;
#(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mp_hca_add_seq_if.slave   bus,
  output logic              busy
);
  localparam int NCHUNK = W / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (!w_ok(W)) begin : g_bad_w
    $error("mp_hca_add_seq: W must be a positive multiple of CHUNK");
  end
  state_t state, state_nxt;
  logic [W-1:0] a_sh, b_sh, sum_sh;
  logic [IW-1:0] idx;
  logic carry, a_msb, b_msb, accept, last, cin0, b_msb0;
  logic [CHUNK-1:0] y;
  logic [CHUNK:0] s;
`ifdef MPADD_SUB_EN
  logic sub_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sub_q <= 1'b0;
    else if (accept) sub_q <= bus.in_sub;
  assign y = sub_q ? ~b_sh[CHUNK-1:0] : b_sh[CHUNK-1:0];
  assign cin0 = bus.in_sub | bus.in_cin;
  assign b_msb0 = bus.in_b[W-1] ^ bus.in_sub;
`else
  logic unused_sub;
  assign unused_sub = bus.in_sub;
  assign y = b_sh[CHUNK-1:0];
  assign cin0 = bus.in_cin;
  assign b_msb0 = bus.in_b[W-1];
`endif
  hca16_cin u_hca (.x(a_sh[CHUNK-1:0]), .y(y), .cin(carry), .s(s));
  assign accept = bus.in_valid && bus.in_ready;
  assign last = idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (bus.out_ready ? IDLE : DONE);
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      idx <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.in_a;
      b_sh <= bus.in_b;
      idx <= '0;
      carry <= cin0;
      a_msb <= bus.in_a[W-1];
      b_msb <= b_msb0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> CHUNK;
      b_sh <= b_sh >> CHUNK;
      sum_sh <= (sum_sh >> CHUNK) | (W'(s[CHUNK-1:0]) << (W - CHUNK));
      carry <= s[CHUNK];
      idx <= idx + IW'(1);
    end
  assign bus.out_sum = sum_sh;
  assign bus.out_cout = carry;
  assign bus.out_ovf = (a_msb == b_msb) && (sum_sh[W-1] != a_msb);
endmodule

// File: tb/tb_mp_hca_add_seq.sv
// tb_mp_hca_add_seq: directed self-checking bench for the multi-precision add sequencer
module tb_mp_hca_add_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mp_hca_add_seq_if #(.W(64)) bus ();
  mp_hca_add_seq #(.W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
    bus.in_sub = sub;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 64'h0) begin n_err++; $display("FAIL reset out_sum got %h want 0", bus.out_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf, busy} !== 3'b000) begin n_err++; $display("FAIL reset cout/ovf/busy got %b want 000", {bus.out_cout, bus.out_ovf, busy}); end
  endtask

  task automatic test_add_basic();
    int lat;
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic busy got %b want 1", busy); end
    wait_valid(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic latency got %0d want 4", lat); end
    n_cmp++; if (bus.out_sum !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL basic sum got %h want 0000000000010000", bus.out_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf} !== 2'b00) begin n_err++; $display("FAIL basic cout/ovf got %b want 00", {bus.out_cout, bus.out_ovf}); end
    handshake();
    n_cmp++; if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin n_err++; $display("FAIL basic post-handshake valid/ready/busy got %b want 010", {bus.out_valid, bus.in_ready, busy}); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_valid(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ripple latency got %0d want 4", lat); end
    n_cmp++; if (bus.out_sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL ripple sum got %h want ffffffffffffffff", bus.out_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf} !== 2'b10) begin n_err++; $display("FAIL ripple cout/ovf got %b want 10", {bus.out_cout, bus.out_ovf}); end
    handshake();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_valid(lat);
    n_cmp++; if (bus.out_sum !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf sum got %h want 8000000000000000", bus.out_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf} !== 2'b01) begin n_err++; $display("FAIL ovf cout/ovf got %b want 01", {bus.out_cout, bus.out_ovf}); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin n_err++; $display("FAIL midrst async ready/valid/busy got %b want 100", {bus.in_ready, bus.out_valid, busy}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen |= bus.out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst out_valid rose got %b want 0", seen); end
    n_cmp++; if (bus.out_sum !== 64'h0) begin n_err++; $display("FAIL midrst out_sum got %h want 0", bus.out_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf, busy, bus.in_ready} !== 4'b0001) begin n_err++; $display("FAIL midrst cout/ovf/busy/ready got %b want 0001", {bus.out_cout, bus.out_ovf, busy, bus.in_ready}); end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(64'h1, 64'h2, 1'b0, 1'b0);
    bus.in_a = 64'h3;
    bus.in_b = 64'h4;
    bus.in_valid = 1'b1;
    wait_valid(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp latency got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (bus.out_sum !== 64'h3) begin n_err++; $display("FAIL bp hold sum cyc %0d got %h want 3", i, bus.out_sum); end
      n_cmp++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin n_err++; $display("FAIL bp hold ready/valid cyc %0d got %b want 01", i, {bus.in_ready, bus.out_valid}); end
      @(posedge clk);
      #1;
    end
    handshake();
    n_cmp++; if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin n_err++; $display("FAIL bp after handshake ready/valid/busy got %b want 100", {bus.in_ready, bus.out_valid, busy}); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.in_ready, busy} !== 2'b01) begin n_err++; $display("FAIL bp next accept ready/busy got %b want 01", {bus.in_ready, busy}); end
    wait_valid(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp second latency got %0d want 4", lat); end
    n_cmp++; if (bus.out_sum !== 64'h7) begin n_err++; $display("FAIL bp second sum got %h want 7", bus.out_sum); end
    handshake();
  endtask

  task automatic test_sub();
    int lat;
    logic [63:0] exp_sum;
`ifdef MPADD_SUB_EN
    exp_sum = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    exp_sum = 64'd12;
`endif
    start_op(64'd5, 64'd7, 1'b0, 1'b1);
    wait_valid(lat);
    n_cmp++; if (bus.out_sum !== exp_sum) begin n_err++; $display("FAIL sub sum got %h want %h", bus.out_sum, exp_sum); end
    n_cmp++; if ({bus.out_cout, bus.out_ovf} !== 2'b00) begin n_err++; $display("FAIL sub cout/ovf got %b want 00", {bus.out_cout, bus.out_ovf}); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_ripple();
    test_overflow();
    test_reset_mid_run();
    test_backpressure();
    test_sub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
